// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if
//   Groups the sequencer's control, instruction-memory, execute/compare
//   handshakes and status lines into one bundle.
//   master : the sequencer (drives requests, strobes, PC controls, status)
//   slave  : the surrounding datapath / memory / testbench
interface fetch_sequencer_if;
  logic        run;
  logic [15:0] pc_addr;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic        exec_start;
  logic        exec_done;
  logic        cmp_start;
  logic        cmp_valid;
  logic        cmp_eq;
  logic        pc_step;
  logic [1:0]  jump_control;
  logic [14:0] load_data;
  logic        eq_flag;
  logic        roll_over;
  logic        busy;
  logic        halted;
  logic        fault;

  modport master (
    input  run, pc_addr, imem_ack, imem_data, exec_done, cmp_valid, cmp_eq,
    output imem_req, imem_addr, exec_start, cmp_start, pc_step, jump_control,
           load_data, eq_flag, roll_over, busy, halted, fault
  );

  modport slave (
    output run, pc_addr, imem_ack, imem_data, exec_done, cmp_valid, cmp_eq,
    input  imem_req, imem_addr, exec_start, cmp_start, pc_step, jump_control,
           load_data, eq_flag, roll_over, busy, halted, fault
  );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Instruction sequencer: fetches a word at pc_addr, decodes opcode [15:12],
//   starts execution or a branch compare, then issues a single PC update
//   strobe with jump type, target/offset and the latched compare result.
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous active-low reset
//     bus  - fetch_sequencer_if.master (run/pc_addr in, imem handshake,
//            exec/cmp handshakes, PC update controls, busy/halted/fault)
//   Parameters:
//     MEM_TIMEOUT - FETCH cycles without imem_ack before faulting
//     PC_LIMIT    - PC value at which a sequential step rolls over to 0
module fetch_sequencer #(
  parameter int          MEM_TIMEOUT = 15,
  parameter logic [15:0] PC_LIMIT    = 16'hFFFE
) (
  input logic               clk,
  input logic               rst,
  fetch_sequencer_if.master bus
);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXEC, BRANCH, UPDATE, HALT
  } state_t;

  state_t        state;
  logic [15:0]   ir;
  logic [CW-1:0] wait_cnt;
  logic          run_q;
  logic          imem_req, exec_start, cmp_start, pc_step;
  logic          eq_flag, busy, halted, fault;
  logic [1:0]    jump_control;
  logic [14:0]   load_data;
  logic [3:0]    op;

  assign op = ir[15:12];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      ir           <= '0;
      wait_cnt     <= '0;
      run_q        <= 1'b0;
      imem_req     <= 1'b0;
      exec_start   <= 1'b0;
      cmp_start    <= 1'b0;
      pc_step      <= 1'b0;
      jump_control <= 2'b00;
      load_data    <= '0;
      eq_flag      <= 1'b0;
      busy         <= 1'b0;
      halted       <= 1'b0;
      fault        <= 1'b0;
    end else begin
      // Strobes are single-cycle by construction: cleared every cycle and
      // only set on the transition that enters the owning state.
      exec_start <= 1'b0;
      cmp_start  <= 1'b0;
      pc_step    <= 1'b0;
      run_q      <= bus.run;
      case (state)
        // run must be seen on two consecutive edges so the first fetch after
        // reset (or after a stop) never appears on the first edge.
        IDLE: if (bus.run && run_q) begin
          state    <= FETCH;
          imem_req <= 1'b1;
          busy     <= 1'b1;
          wait_cnt <= '0;
        end
        FETCH: begin
          if (bus.imem_ack) begin
            ir       <= bus.imem_data;
            imem_req <= 1'b0;
            state    <= DECODE;
          end else if (wait_cnt == CW'(MEM_TIMEOUT - 1)) begin
            imem_req <= 1'b0;
            busy     <= 1'b0;
            halted   <= 1'b1;
            fault    <= 1'b1;
            state    <= HALT;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        DECODE: begin
          case (op)
            4'hC: begin
              jump_control <= 2'b01;
              load_data    <= {3'b000, ir[11:0]};
              pc_step      <= 1'b1;
              state        <= UPDATE;
            end
            4'hD, 4'hE: begin
              jump_control <= (op == 4'hD) ? 2'b10 : 2'b11;
              load_data    <= {{7{ir[7]}}, ir[7:0]};
              cmp_start    <= 1'b1;
              state        <= BRANCH;
            end
            4'hF: begin
              busy   <= 1'b0;
              halted <= 1'b1;
              state  <= HALT;
            end
            default: begin
              jump_control <= 2'b00;
              load_data    <= '0;
              exec_start   <= 1'b1;
              state        <= EXEC;
            end
          endcase
        end
        EXEC: if (bus.exec_done) begin
          pc_step <= 1'b1;
          state   <= UPDATE;
        end
        BRANCH: if (bus.cmp_valid) begin
          eq_flag <= bus.cmp_eq;
          pc_step <= 1'b1;
          state   <= UPDATE;
        end
        UPDATE: begin
          if (bus.run) begin
            imem_req <= 1'b1;
            wait_cnt <= '0;
            state    <= FETCH;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        HALT: if (!bus.run) begin
          halted <= 1'b0;
          fault  <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // imem_addr tracks the live PC only while a request is outstanding.
  assign bus.imem_addr    = imem_req ? bus.pc_addr : 16'h0000;
  // Roll-over compares against the PC present during the update strobe.
  assign bus.roll_over    = pc_step && (jump_control == 2'b00) &&
                            (bus.pc_addr == PC_LIMIT);
  assign bus.imem_req     = imem_req;
  assign bus.exec_start   = exec_start;
  assign bus.cmp_start    = cmp_start;
  assign bus.pc_step      = pc_step;
  assign bus.jump_control = jump_control;
  assign bus.load_data    = load_data;
  assign bus.eq_flag      = eq_flag;
  assign bus.busy         = busy;
  assign bus.halted       = halted;
  assign bus.fault        = fault;
endmodule
